// File: rtl/mod_seq_ctrl.sv
// Run-time sequencer for the AM/FM modulator datapath.
// Shadows settings, applies them at safe points, gates sample flow.
module mod_seq_ctrl #(
    parameter int LAT     = 7,
    parameter int RST_CYC = 2,
    parameter int CW      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [23:0] wr_data,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [15:0] mod_i_data,
    output logic        mod_val_in,
    output logic        mod_rst,
    output logic        c_fm_am,
    output logic [23:0] frec_por,
    output logic [15:0] im_am,
    output logic [15:0] im_fm,
    input  logic        mod_val_out,
    output logic        m_valid,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_RESET  = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RUN    = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

    localparam logic [CW-1:0] LAT_T = CW'(LAT - 1);
    localparam logic [CW-1:0] RST_T = CW'(RST_CYC - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_term;
    logic          pend;

    logic [23:0]   sh_frec;
    logic [15:0]   sh_am;
    logic [15:0]   sh_fm;
    logic          sh_fm_sel;
    logic          sh_en;

    logic          ctl_wr;
    logic          commit;
    logic          en_now;

    // A control write's enable takes effect for the commit it carries
    assign ctl_wr = wr_en && (wr_addr == 2'd3);
    assign commit = ctl_wr && wr_data[2];
    assign en_now = ctl_wr ? wr_data[1] : sh_en;

    // Shadow settings follow every write, whatever the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_frec   <= '0;
            sh_am     <= '0;
            sh_fm     <= '0;
            sh_fm_sel <= 1'b0;
            sh_en     <= 1'b0;
        end else if (wr_en) begin
            unique case (wr_addr)
                2'd0: sh_frec <= wr_data;
                2'd1: sh_am   <= wr_data[15:0];
                2'd2: sh_fm   <= wr_data[15:0];
                2'd3: begin
                    sh_fm_sel <= wr_data[0];
                    sh_en     <= wr_data[1];
                end
            endcase
        end
    end

    // Next-state decode of the apply/reset/settle/run/drain sequence
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (commit && en_now) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = S_RESET;
            S_RESET:  if (cnt == RST_T) state_nxt = S_SETTLE;
            S_SETTLE: if (cnt == LAT_T) state_nxt = S_RUN;
            S_RUN:    if (pend || commit) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (cnt == LAT_T) state_nxt = en_now ? S_APPLY : S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // APPLY counts as the first reset cycle, so it shares RESET's limit
    assign cnt_term = (state == S_APPLY || state == S_RESET) ? RST_T : LAT_T;

    // State register and the registered datapath reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            mod_rst <= 1'b1;
        end else begin
            state   <= state_nxt;
            mod_rst <= (state_nxt == S_IDLE) || (state_nxt == S_APPLY) ||
                       (state_nxt == S_RESET);
        end
    end

    // Saturating phase counter; carries across APPLY into RESET
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_nxt != state && state != S_APPLY) begin
            cnt <= '0;
        end else if (state == S_IDLE || state == S_RUN) begin
            cnt <= '0;
        end else if (cnt != cnt_term) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Commits arriving mid-sequence are remembered until RUN or DRAIN exit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= 1'b0;
        end else if (state == S_RUN) begin
            pend <= 1'b0;
        end else if (state == S_DRAIN && cnt == LAT_T) begin
            pend <= 1'b0;
        end else if (commit && state != S_IDLE) begin
            pend <= 1'b1;
        end
    end

    // Active settings are loaded only while in APPLY
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frec_por <= '0;
            im_am    <= '0;
            im_fm    <= '0;
            c_fm_am  <= 1'b0;
        end else if (state == S_APPLY) begin
            frec_por <= sh_frec;
            im_am    <= sh_am;
            im_fm    <= sh_fm_sel ? sh_fm : 16'd0;
            c_fm_am  <= sh_fm_sel;
        end
    end

    assign s_ready    = (state == S_RUN) && !pend;
    assign mod_i_data = s_data;
    assign mod_val_in = s_valid && s_ready;
    assign m_valid    = mod_val_out && (state == S_RUN || state == S_DRAIN);
    assign busy       = !(state == S_IDLE || state == S_RUN);

endmodule

// File: tb/tb_mod_seq_ctrl.sv
// Bench for mod_seq_ctrl with a simple delay-line datapath model.
// Accepted samples are queued and matched against m_valid pulses.
module tb_mod_seq_ctrl;

    localparam int LAT = 7;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [23:0] wr_data;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] mod_i_data;
    logic        mod_val_in;
    logic        mod_rst;
    logic        c_fm_am;
    logic [23:0] frec_por;
    logic [15:0] im_am;
    logic [15:0] im_fm;
    logic        mod_val_out;
    logic        m_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int mv_count = 0;
    logic [15:0] sb[$];

    mod_seq_ctrl #(.LAT(LAT), .RST_CYC(2), .CW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .mod_i_data  (mod_i_data),
        .mod_val_in  (mod_val_in),
        .mod_rst     (mod_rst),
        .c_fm_am     (c_fm_am),
        .frec_por    (frec_por),
        .im_am       (im_am),
        .im_fm       (im_fm),
        .mod_val_out (mod_val_out),
        .m_valid     (m_valid),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: fixed LAT-cycle delay line, cleared by mod_rst
    logic [LAT-1:0] pv;
    logic [15:0]    pd [LAT];
    always @(posedge clk) begin
        if (mod_rst) begin
            pv <= '0;
        end else begin
            pv <= {pv[LAT-2:0], mod_val_in};
            pd[0] <= mod_i_data;
            for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
        end
    end
    assign mod_val_out = pv[LAT-1];

    // Monitor: every unmasked output must match the oldest queued sample
    always @(negedge clk) begin
        if (m_valid) begin
            mv_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL m_valid_extra: got pulse data %h, expected none",
                         pd[LAT-1]);
            end else begin
                logic [15:0] want;
                want = sb.pop_front();
                if (pd[LAT-1] !== want) begin
                    errors++;
                    $display("FAIL m_valid_data: got %h expected %h",
                             pd[LAT-1], want);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic write_cfg(input logic [1:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic stream(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            chk("s_ready_stream", s_ready, 1);
            s_valid = 1'b1;
            s_data  = base + 16'(i);
            sb.push_back(base + 16'(i));
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        s_data  = '0;
        s_valid = 1'b0;

        // 1: reset and idle
        repeat (3) @(negedge clk);
        chk("rst_mod_rst", mod_rst, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_mod_rst", mod_rst, 1);
        chk("idle_s_ready", s_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_frec", frec_por, 0);
        chk("idle_im_am", im_am, 0);
        chk("idle_im_fm", im_fm, 0);
        chk("idle_c_fm_am", c_fm_am, 0);

        // 2: first apply, RUN 10 cycles after commit
        write_cfg(2'd0, 24'h051EB8);
        write_cfg(2'd1, 24'h004000);
        write_cfg(2'd3, 24'h000006);
        for (int k = 1; k <= 10; k++) begin
            chk("t2_mod_rst", mod_rst, (k <= 2) ? 1 : 0);
            chk("t2_s_ready", s_ready, (k >= 10) ? 1 : 0);
            chk("t2_busy", busy, (k < 10) ? 1 : 0);
            if (k < 10) @(negedge clk);
        end
        chk("t2_frec", frec_por, 32'h051EB8);
        chk("t2_im_am", im_am, 32'h4000);
        chk("t2_c_fm_am", c_fm_am, 0);
        chk("t2_im_fm", im_fm, 0);

        // 3: stream 10, recommit into FM mode
        write_cfg(2'd2, 24'h000100);
        mv_count = 0;
        stream(10, 16'h1000);
        write_cfg(2'd3, 24'h000007);
        for (int k = 1; k <= 17; k++) begin
            chk("t3_s_ready", s_ready, (k >= 17) ? 1 : 0);
            chk("t3_mod_rst", mod_rst, (k == 8 || k == 9) ? 1 : 0);
            if (k == 8) begin
                #1;
                chk("t3_mv_count", mv_count, 10);
                chk("t3_sb_empty", sb.size(), 0);
            end
            if (k < 17) @(negedge clk);
        end
        chk("t3_c_fm_am", c_fm_am, 1);
        chk("t3_im_fm", im_fm, 32'h0100);
        chk("t3_frec", frec_por, 32'h051EB8);

        // 4: commit in SETTLE leaves RUN immediately with no samples
        for (int k = 0; k <= 34; k++) begin
            if (k >= 1) begin
                chk("t4_s_ready", s_ready, (k >= 34) ? 1 : 0);
                chk("t4_mod_rst", mod_rst,
                    (k == 8 || k == 9 || k == 25 || k == 26) ? 1 : 0);
                chk("t4_busy", busy, (k == 17 || k == 34) ? 0 : 1);
            end
            wr_en   = (k == 0 || k == 12);
            wr_addr = 2'd3;
            wr_data = 24'h000007;
            s_valid = (k >= 13 && k <= 33);
            s_data  = 16'h7F00 + 16'(k);
            if (k < 34) @(negedge clk);
        end
        wr_en   = 1'b0;
        s_valid = 1'b0;

        // 5: disable from RUN, last-cycle sample exits inside DRAIN
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = 24'h000004;
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        sb.push_back(16'hBEEF);
        @(negedge clk);
        wr_en   = 1'b0;
        s_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("t5_mod_rst", mod_rst, (k == 8) ? 1 : 0);
            chk("t5_busy", busy, (k < 8) ? 1 : 0);
            chk("t5_s_ready", s_ready, 0);
            if (k < 8) @(negedge clk);
        end
        chk("t5_sb_empty", sb.size(), 0);
        chk("t5_c_fm_am_kept", c_fm_am, 1);
        write_cfg(2'd3, 24'h000004);
        repeat (2) @(negedge clk);
        chk("t5_idle_stay_busy", busy, 0);
        chk("t5_idle_stay_rst", mod_rst, 1);

        // 6: AM re-apply, then reset in DRAIN with outputs in flight
        write_cfg(2'd3, 24'h000006);
        repeat (9) @(negedge clk);
        chk("t6_s_ready", s_ready, 1);
        chk("t6_c_fm_am", c_fm_am, 0);
        chk("t6_im_fm_forced", im_fm, 0);
        chk("t6_frec", frec_por, 32'h051EB8);
        stream(10, 16'h2000);
        write_cfg(2'd3, 24'h000006);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_mod_rst", mod_rst, 1);
        chk("t6_rst_s_ready", s_ready, 0);
        chk("t6_rst_m_valid", m_valid, 0);
        chk("t6_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        chk("t6_clr_frec", frec_por, 0);
        chk("t6_clr_im_am", im_am, 0);
        write_cfg(2'd3, 24'h000006);
        repeat (9) @(negedge clk);
        chk("t6_rerun_s_ready", s_ready, 1);
        chk("t6_shadow_frec", frec_por, 0);
        chk("t6_shadow_im_am", im_am, 0);
        repeat (10) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
